idct_2d_ctrl: RTL and testbench

Sequencer that computes an N×N 2-D inverse DCT by running one shared `IDCT_1D` core twice: a row pass, an internal transpose, a column pass, then a transpose back. It sits between the coefficient source (dequantiser) and the pixel sink and owns the core's `start`/`done` handshake. It also provides valid/ready flow control on both sides and a watchdog against a hung core.

---
 rtl/idct_2d_ctrl.sv | 139 +++++++++++++
 tb/tb_idct_2d_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_2d_ctrl.sv
// Purpose : sequences one shared 1-D IDCT core through row pass, transpose, column pass, transpose.
// Latency : accept -> out_valid = 2*Lc + 3 cycles (Lc = core start-to-done latency).
// Backpr. : one block in flight; in_ready only in IDLE, out_valid/out_blk held until out_ready.
//
// Ports:
//   clk, reset             - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      - coefficient block handshake, in_blk packed [r][c] at (r*N+c)*16
//   core_start/core_done   - one-cycle start pulse to the core, done may be a pulse or a level
//   core_x/core_y          - core input/output matrices, same packing as in_blk
//   out_valid/out_ready    - result handshake, out_blk same packing
//   busy, err_timeout      - non-IDLE indicator, sticky watchdog flag (cleared by next accept)
module idct_2d_ctrl #(
  parameter int N         = 4,
  parameter int BIT_DEPTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*N*16-1:0]   in_blk,
  output logic                core_start,
  output logic [N*N*16-1:0]   core_x,
  input  logic [N*N*16-1:0]   core_y,
  input  logic                core_done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*16-1:0]   out_blk,
  output logic                busy,
  output logic                err_timeout
);

  // BIT_DEPTH only configures the attached core; it is folded in with weight
  // zero so the parameter is visibly consumed without affecting the counter.
  localparam int CW = $clog2(TIMEOUT + 1) + 0 * BIT_DEPTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START1 = 3'd1,
    WAIT1  = 3'd2,
    START2 = 3'd3,
    WAIT2  = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t          state;
  logic            done_q;
  logic [CW-1:0]   wd_cnt;
  logic            done_rise;

  // Edge detection lets a core that parks done high still be tracked: only
  // a fresh rising edge inside a WAIT state advances the sequence.
  assign done_rise = core_done & ~done_q;

  // Outputs are pure decodes of the state register, so they drop at once on
  // an asynchronous reset.
  assign in_ready   = (state == IDLE);
  assign core_start = (state == START1) || (state == START2);
  assign out_valid  = (state == OUT);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      wd_cnt      <= '0;
      core_x      <= '0;
      out_blk     <= '0;
      err_timeout <= 1'b0;
    end else begin
      done_q <= core_done;
      case (state)
        IDLE: begin
          if (in_valid) begin
            core_x      <= in_blk;
            err_timeout <= 1'b0;
            state       <= START1;
          end
        end

        START1: begin
          wd_cnt <= '0;
          state  <= WAIT1;
        end

        // A done_rise on the final allowed cycle beats the watchdog.
        WAIT1: begin
          if (done_rise) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                core_x[(r*N+c)*16 +: 16] <= core_y[(c*N+r)*16 +: 16];
              end
            end
            state <= START2;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end

        START2: begin
          wd_cnt <= '0;
          state  <= WAIT2;
        end

        WAIT2: begin
          if (done_rise) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                out_blk[(r*N+c)*16 +: 16] <= core_y[(c*N+r)*16 +: 16];
              end
            end
            state <= OUT;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end

        // No accept here even if in_valid is high: in_ready only rises once
        // the state is back in IDLE.
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_2d_ctrl.sv
module tb_idct_2d_ctrl;

  localparam int N  = 4;
  localparam int W  = N * N * 16;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_blk = '0;
  logic         core_start;
  logic [W-1:0] core_x;
  logic [W-1:0] core_y = '0;
  logic         core_done = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_blk;
  logic         busy;
  logic         err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int stub_mode = 0;   // 0: done pulse, 1: done level until next start, 2: never done
  int stub_lat  = 3;
  int stub_cnt  = 0;

  always #5 clk = ~clk;

  idct_2d_ctrl #(.N(N), .BIT_DEPTH(8), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_blk      (in_blk),
    .core_start  (core_start),
    .core_x      (core_x),
    .core_y      (core_y),
    .core_done   (core_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_blk     (out_blk),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Matrix helpers: y[r][c] = x[r][c] + r (16-bit wrap), and plain transpose.
  function automatic logic [W-1:0] row_add(input logic [W-1:0] m);
    logic [W-1:0] res;
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        res[(r*N+c)*16 +: 16] = m[(r*N+c)*16 +: 16] + 16'(r);
    return res;
  endfunction

  function automatic logic [W-1:0] transpose(input logic [W-1:0] m);
    logic [W-1:0] res;
    res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        res[(r*N+c)*16 +: 16] = m[(c*N+r)*16 +: 16];
    return res;
  endfunction

  // Expected 2-D result: T(core(T(core(x)))).
  function automatic logic [W-1:0] ref_idct(input logic [W-1:0] x);
    return transpose(row_add(transpose(row_add(x))));
  endfunction

  function automatic logic [W-1:0] rand_blk();
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N*N; i++) res[i*16 +: 16] = 16'($urandom);
    return res;
  endfunction

  // Core stub with configurable latency: done is high Lc cycles after the start cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt  <= 0;
      core_done <= 1'b0;
    end else if (core_start) begin
      n_starts <= n_starts + 1;
      core_y   <= row_add(core_x);
      if (stub_mode == 2) begin
        core_done <= 1'b0;
        stub_cnt  <= 0;
      end else if (stub_lat <= 1) begin
        core_done <= 1'b1;
        stub_cnt  <= 0;
      end else begin
        core_done <= 1'b0;
        stub_cnt  <= stub_lat - 1;
      end
    end else begin
      if (stub_mode == 0) core_done <= 1'b0;
      if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) core_done <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string ph);
    check({ph, "_in_ready"},    in_ready,    1);
    check({ph, "_core_start"},  core_start,  0);
    check({ph, "_out_valid"},   out_valid,   0);
    check({ph, "_busy"},        busy,        0);
    check({ph, "_err_timeout"}, err_timeout, 0);
    check({ph, "_core_x"},      core_x,      '0);
    check({ph, "_out_blk"},     out_blk,     '0);
  endtask

  // Leaves the bench in the cycle right after the accepting edge (START1).
  task automatic accept(input logic [W-1:0] blk);
    int k;
    k = 0;
    in_blk   = blk;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("start_after_accept", core_start, 1);
  endtask

  // cyc counts cycles since the accepting edge (START1 is cycle 1).
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_handshake", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] blks [3];
    logic [W-1:0] exps [3];
    int cyc;
    int s0;
    int edge_n;
    int acc_i;
    int out_i;
    int last_hs;
    logic seen;
    logic acc_now;
    logic hs_now;

    // Reset values
    #2 reset = 1'b1;
    #1 check_reset_vals("rst");
    #10;
    @(negedge clk) reset = 1'b0;
    tick();

    // Transpose correctness: zero block, pulse done at Lc = 3
    stub_mode = 0; stub_lat = 3;
    b = '0;
    accept(b);
    wait_out(cyc);
    check("t1_latency", cyc, 9);
    check("t1_out", out_blk, ref_idct(b));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check("t1_elem_r_plus_c", out_blk[(r*N+c)*16 +: 16], 16'(r + c));
    release_out();

    // Level done: [0][0] = 1000
    stub_mode = 1;
    b = '0;
    b[15:0] = 16'd1000;
    s0 = n_starts;
    accept(b);
    wait_out(cyc);
    check("t2_latency", cyc, 9);
    check("t2_out", out_blk, ref_idct(b));
    check("t2_elem00", out_blk[15:0], 16'd1000);
    release_out();
    repeat (3) tick();
    check("t2_start_pulses", n_starts - s0, 2);

    // Backpressure with random data, Lc = 2
    stub_mode = 0; stub_lat = 2;
    b = rand_blk();
    accept(b);
    check("t3_core_x", core_x, b);
    wait_out(cyc);
    check("t3_latency", cyc, 7);
    e = ref_idct(b);
    check("t3_out", out_blk, e);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_blk", out_blk, e);
      check("t3_in_ready", in_ready, 0);
      check("t3_busy", busy, 1);
      check("t3_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_idle_ready", in_ready, 1);
    check("t3_idle_busy", busy, 0);
    check("t3_idle_valid", out_valid, 0);

    // Timeout: core never signals done
    stub_mode = 2;
    b = rand_blk();
    accept(b);
    seen = 1'b0;
    repeat (16) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t4_no_err_before", err_timeout, 0);
    check("t4_busy_before", busy, 1);
    tick();
    check("t4_err_set", err_timeout, 1);
    check("t4_in_ready", in_ready, 1);
    check("t4_busy_after", busy, 0);
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t4_no_out_valid", seen, 0);
    check("t4_err_sticky", err_timeout, 1);
    stub_mode = 0; stub_lat = 3;
    b = rand_blk();
    accept(b);
    check("t4_err_cleared", err_timeout, 0);
    wait_out(cyc);
    check("t4_recover_out", out_blk, ref_idct(b));
    release_out();

    // Timeout boundary: done on the last allowed cycle wins
    stub_lat = 16;
    b = rand_blk();
    accept(b);
    wait_out(cyc);
    check("t5_boundary_latency", cyc, 35);
    check("t5_boundary_no_err", err_timeout, 0);
    check("t5_boundary_out", out_blk, ref_idct(b));
    release_out();

    // One cycle too late: timeout
    stub_lat = 17;
    b = rand_blk();
    s0 = n_starts;
    accept(b);
    repeat (16) tick();
    check("t5_late_no_err_yet", err_timeout, 0);
    tick();
    check("t5_late_err", err_timeout, 1);
    check("t5_late_idle", in_ready, 1);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t5_late_no_out", seen, 0);
    check("t5_late_one_start", n_starts - s0, 1);

    // Reset asserted between edges during WAIT2
    stub_lat = 3;
    b = rand_blk();
    accept(b);
    repeat (5) tick();
    check("t6_in_wait2_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check_reset_vals("mid");
    #3 reset = 1'b0;
    tick();
    b = rand_blk();
    accept(b);
    wait_out(cyc);
    check("t6_fresh_latency", cyc, 9);
    check("t6_fresh_out", out_blk, ref_idct(b));
    release_out();

    // Back-to-back blocks with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      blks[i] = rand_blk();
      exps[i] = ref_idct(blks[i]);
    end
    in_blk    = blks[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    edge_n = 0; acc_i = 0; out_i = 0; last_hs = 0;
    while (out_i < 3 && edge_n < 300) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      if (hs_now) begin
        check("t7_result_order", out_blk, exps[out_i]);
        last_hs = edge_n;
        out_i++;
      end
      if (acc_now) begin
        if (acc_i > 0) check("t7_accept_gap", edge_n - last_hs, 1);
        acc_i++;
      end
      tick();
      edge_n++;
      if (acc_now) begin
        if (acc_i < 3) in_blk = blks[acc_i];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t7_result_count", out_i, 3);
    check("t7_accept_count", acc_i, 3);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
